adc_spi_scanner: RTL and testbench



---
 rtl/adc_pkg.sv | 19 +
 rtl/clk_en_divider.sv | 30 +++
 rtl/adc_spi_scanner.sv | 168 ++++++++++++++++
 tb/tb_adc_spi_scanner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and frame constants for the scanning SPI ADC controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  // Command bits sent MSB first: start, SGL/DIFF, D2, D1, D0.
  localparam int CMD_BITS        = 5;
  // Rises 6..NULL_RISE are the sample/null period; data starts after.
  localparam int NULL_RISE       = 7;
  localparam int FIRST_DATA_RISE = NULL_RISE + 1;
  localparam int FRAME_RISES     = 19;

  function automatic logic [CMD_BITS-1:0] adc_cmd(input logic diff, input logic [2:0] ch);
    return {1'b1, ~diff, ch};
  endfunction

endpackage

// File: rtl/clk_en_divider.sv
// Half-period clock-enable generator: tick pulses for one clk every DIV clks.
// Latency: first tick DIV clks after clr drops; clr holds the count at zero.
// Backpressure: none, free running while clr is low.
// Ports: clk, rst (sync, active-high), clr (hold/restart), tick (enable pulse).
module clk_en_divider #(
  parameter int DIV = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/adc_spi_scanner.sv
// Round-robin MCP3204-style SPI ADC scanner with a tagged valid/ready result port.
// Latency: start -> cs_n low 1 clk; cs_n low -> sample_valid 39*CLK_DIV+1 clks.
// Backpressure: one result register; a result arriving while it is still held
//   and not being accepted is dropped and sets sticky overrun.
// Ports: clk/rst; start, continuous, diff_mode, chan_mask (control);
//   sclk, cs_n, mosi, miso (SPI); sample_data/chan/valid/ready (result);
//   busy, overrun (status).
module adc_spi_scanner
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 500,
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12,
  parameter int CS_IDLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              diff_mode,
  input  logic [NUM_CH-1:0] chan_mask,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] sample_data,
  output logic [2:0]        sample_chan,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int HW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  state_t            state;
  logic              tick;
  logic [4:0]        rise_cnt;
  logic [2:0]        ch;
  logic [2:0]        ptr;
  logic              dm;
  logic [DATA_W-1:0] shreg;
  logic [HW-1:0]     hold_cnt;
  logic              post;

  logic              sel_found;
  logic [2:0]        sel_ch;
  logic [3:0]        idx;
  logic [NUM_CH-1:0] rot;
  logic [CMD_BITS-1:0] cmd_sh;
  logic              cmd_next;

  // Divider is held cleared in IDLE, so every frame starts on a fresh phase.
  clk_en_divider #(.DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // First enabled channel at or above the pointer, wrapping upward.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    idx       = '0;
    rot       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(NUM_CH)) idx = idx - 4'(NUM_CH);
      rot = chan_mask >> idx;
      if (!sel_found && rot[0]) begin
        sel_found = 1'b1;
        sel_ch    = idx[2:0];
      end
    end
  end

  // Bit to present after the falling edge that follows rise rise_cnt.
  always_comb begin
    cmd_sh   = adc_cmd(dm, ch) << rise_cnt;
    cmd_next = (rise_cnt < 5'(CMD_BITS)) ? cmd_sh[CMD_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_chan  <= '0;
      rise_cnt     <= '0;
      ch           <= '0;
      ptr          <= '0;
      dm           <= 1'b0;
      shreg        <= '0;
      hold_cnt     <= '0;
      post         <= 1'b0;
    end else begin
      post <= 1'b0;

      if (sample_valid && sample_ready) sample_valid <= 1'b0;

      // Posting runs in the first CS_HOLD cycle; an accept in that same
      // cycle frees the register, so the new result is not an overrun.
      if (post) begin
        if (!sample_valid || sample_ready) begin
          sample_data  <= shreg;
          sample_chan  <= ch;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
        ptr <= (ch == 3'(NUM_CH - 1)) ? 3'd0 : ch + 3'd1;
      end

      case (state)
        IDLE: begin
          if ((start || continuous) && sel_found) begin
            state    <= CS_SETUP;
            cs_n     <= 1'b0;
            mosi     <= 1'b1;
            ch       <= sel_ch;
            dm       <= diff_mode;
            busy     <= 1'b1;
            rise_cnt <= '0;
          end
        end
        CS_SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk     <= 1'b1;
              rise_cnt <= rise_cnt + 5'd1;
              if (rise_cnt >= 5'(NULL_RISE)) shreg <= {shreg[DATA_W-2:0], miso};
            end else begin
              sclk <= 1'b0;
              mosi <= cmd_next;
              if (rise_cnt == 5'(FRAME_RISES)) begin
                state    <= CS_HOLD;
                cs_n     <= 1'b1;
                post     <= 1'b1;
                hold_cnt <= '0;
              end
            end
          end
        end
        CS_HOLD: begin
          if (tick) begin
            if (hold_cnt == HW'(CS_IDLE - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Bench for adc_spi_scanner: ADC slave model, frame-level reference model and
// per-cycle compare of the result port, plus directed scenarios.
module tb_adc_spi_scanner;

  localparam int DIV = 4;
  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int CSI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic diff_mode = 1'b0;
  logic [NCH-1:0] chan_mask = '0;
  logic miso = 1'b0;
  logic sample_ready = 1'b0;
  logic sclk, cs_n, mosi, sample_valid, busy, overrun;
  logic [DW-1:0] sample_data;
  logic [2:0] sample_chan;

  int errors = 0;
  int checks = 0;

  adc_spi_scanner #(.CLK_DIV(DIV), .NUM_CH(NCH), .DATA_W(DW), .CS_IDLE(CSI)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .diff_mode(diff_mode), .chan_mask(chan_mask), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .sample_data(sample_data), .sample_chan(sample_chan),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ADC slave model ----------------
  logic [DW-1:0] adc_word = '0;
  logic          force_en = 1'b0;
  logic [DW-1:0] force_val = '0;
  int            rises = 0;
  logic [4:0]    mosi_bits = '0;

  always @(negedge cs_n) begin
    rises     = 0;
    mosi_bits = '0;
    adc_word  = force_en ? force_val : DW'($urandom);
  end

  always @(posedge sclk) begin
    rises++;
    if (rises <= 5) mosi_bits = {mosi_bits[3:0], mosi};
  end

  // Data for rise r (8..19) is bit 19-r, driven after the preceding fall.
  always @(negedge sclk) miso = (rises >= 7 && rises <= 18) ? adc_word[18 - rises] : 1'b0;

  // ---------------- reference model + compare ----------------
  logic          m_vld = 1'b0;
  logic          m_ovr = 1'b0;
  logic [DW-1:0] m_dat = '0;
  logic [2:0]    m_ch = '0;
  int            m_ptr = 0;
  int            f_ch = 0;
  logic          f_diff = 1'b0;
  logic          prev_csn = 1'b1;
  logic          prev_rst = 1'b1;
  logic [NCH-1:0] mask_q = '0;
  logic          diff_q = 1'b0;
  int            low_cnt = 0;
  int            high_cnt = 0;
  int            frames = 0;
  bit            seen_frame = 0;
  int            ch_log[$];

  function automatic int pick(input logic [NCH-1:0] m, input int p);
    for (int k = 0; k < NCH; k++) if (m[(p + k) % NCH]) return (p + k) % NCH;
    return 0;
  endfunction

  always @(negedge clk) begin
    logic post;
    logic old_v;
    check("sample_valid", sample_valid, m_vld);
    check("sample_data", sample_data, m_dat);
    check("sample_chan", sample_chan, m_ch);
    check("overrun", overrun, m_ovr);
    if (!cs_n) check("busy_in_frame", busy, 1);
    else       check("sclk_idle_low", sclk, 0);

    post = 1'b0;
    if (!prev_rst) begin
      if (prev_csn && !cs_n) begin
        if (seen_frame) check("cs_gap_ok", (high_cnt >= CSI * DIV), 1);
        f_ch    = pick(mask_q, m_ptr);
        f_diff  = diff_q;
        low_cnt = 0;
      end
      if (!prev_csn && cs_n) begin
        check("frame_rises", rises, 19);
        check("mosi_cmd", mosi_bits, {1'b1, ~f_diff, 3'(f_ch)});
        check("cs_low_cycles", low_cnt, 39 * DIV);
        ch_log.push_back(int'(mosi_bits[2:0]));
        frames++;
        seen_frame = 1;
        high_cnt   = 0;
        post       = 1'b1;
      end
    end
    if (!cs_n) low_cnt++; else high_cnt++;

    if (rst) begin
      m_vld = 0; m_ovr = 0; m_dat = '0; m_ch = '0; m_ptr = 0; seen_frame = 0;
    end else begin
      old_v = m_vld;
      if (m_vld && sample_ready) m_vld = 0;
      if (post) begin
        if (!old_v || sample_ready) begin
          m_vld = 1; m_dat = adc_word; m_ch = 3'(f_ch);
        end else begin
          m_ovr = 1;
        end
        m_ptr = (f_ch + 1) % NCH;
      end
    end
    prev_rst = rst;
    prev_csn = cs_n;
    mask_q   = chan_mask;
    diff_q   = diff_mode;
  end

  // ---------------- stimulus helpers ----------------
  bit rand_ready = 0;
  always @(posedge clk) if (rand_ready) begin
    #1 sample_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    int c;
    target = frames + n;
    c = 0;
    while (frames < target && c < budget) begin @(negedge clk); c++; end
    check("wait_frames_in_time", (frames >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((busy || !cs_n) && c < budget) begin @(negedge clk); c++; end
    check("wait_idle_in_time", (!busy && cs_n), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c;
    int frames_before;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);

    // Single conversion, channel 0, single-ended, fixed ADC word.
    force_en = 1; force_val = 12'hA5C;
    chan_mask = 4'b0001; diff_mode = 0; sample_ready = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    check("start_to_cs_low", cs_n, 0);
    wait_frames(1, 400);
    repeat (3) @(negedge clk);
    check("t1_mosi_bits", mosi_bits, 5'b11000);
    check("t1_rises", rises, 19);
    check("t1_low_cycles", low_cnt, 156);
    check("t1_valid", sample_valid, 1);
    check("t1_data", sample_data, 12'hA5C);
    check("t1_chan", sample_chan, 0);
    check("t1_overrun", overrun, 0);
    wait_idle(100);

    // Continuous scan of channels 1 and 3, differential.
    apply_reset();
    force_en = 0;
    @(posedge clk); #1 chan_mask = 4'b1010; diff_mode = 1; sample_ready = 1; continuous = 1;
    base = ch_log.size();
    wait_frames(4, 1200);
    @(posedge clk); #1 continuous = 0;
    wait_idle(100);
    check("t2_seq0", ch_log[base + 0], 1);
    check("t2_seq1", ch_log[base + 1], 3);
    check("t2_seq2", ch_log[base + 2], 1);
    check("t2_seq3", ch_log[base + 3], 3);
    check("t2_mosi_diff", mosi_bits, 5'b10011);

    // Result held with no consumer: second frame overruns.
    apply_reset();
    force_en = 1; force_val = 12'h3C7;
    @(posedge clk); #1 chan_mask = 4'b0100; diff_mode = 0; sample_ready = 0; continuous = 1;
    wait_frames(1, 400);
    force_val = 12'h5A1;
    repeat (3) @(negedge clk);
    check("t3_valid1", sample_valid, 1);
    check("t3_data1", sample_data, 12'h3C7);
    check("t3_no_ovr_yet", overrun, 0);
    wait_frames(1, 400);
    @(posedge clk); #1 continuous = 0;
    repeat (3) @(negedge clk);
    check("t3_overrun", overrun, 1);
    check("t3_data_held", sample_data, 12'h3C7);
    check("t3_chan_held", sample_chan, 2);
    wait_idle(100);

    // Reset in the middle of the data phase.
    force_en = 0;
    frames_before = frames;
    pulse_start();
    c = 0;
    while (rises < 10 && c < 2000) begin @(negedge clk); c++; end
    check("t4_reach_rise10", (rises >= 10), 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("t4_cs_n", cs_n, 1);
    check("t4_sclk", sclk, 0);
    check("t4_valid", sample_valid, 0);
    check("t4_overrun", overrun, 0);
    repeat (300) @(negedge clk);
    check("t4_no_post", sample_valid, 0);
    check("t4_no_frame", frames, frames_before);

    // Empty mask, then start while busy.
    frames_before = frames;
    @(posedge clk); #1 chan_mask = '0;
    pulse_start();
    repeat (50) @(negedge clk);
    check("t5_mask0_cs_n", cs_n, 1);
    check("t5_mask0_frames", frames, frames_before);
    @(posedge clk); #1 chan_mask = 4'b0100; sample_ready = 1;
    pulse_start();
    repeat (40) @(negedge clk);
    check("t5_busy", busy, 1);
    pulse_start();
    wait_idle(400);
    repeat (20) @(negedge clk);
    check("t5_one_frame", frames, frames_before + 1);

    // Randomized traffic against the model.
    rand_ready = 1;
    for (int it = 0; it < 25; it++) begin
      @(posedge clk); #1;
      chan_mask = NCH'($urandom_range(1, 15));
      diff_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        continuous = 1;
        wait_frames(int'($urandom_range(1, 3)), 2000);
        @(posedge clk); #1 continuous = 0;
      end else begin
        pulse_start();
        wait_frames(1, 600);
      end
      wait_idle(200);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    rand_ready = 0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
